// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/debug unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_MEM_LAT = 8;
    localparam int unsigned CNT_W       = $clog2(MAX_MEM_LAT);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        CAPT,
        RESP
    } arbState_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } reqId_t;

endpackage

// File: rtl/rr2_picker.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the side
// that was not granted last.
module rr2_picker
    import mem_arb_pkg::*;
(
    input  logic   cpuReq,
    input  logic   dbgReq,
    input  reqId_t lastGrant,
    output logic   grantValid_c,
    output reqId_t grantId_c
);

    always_comb begin
        grantValid_c = cpuReq | dbgReq;
        grantId_c    = REQ_CPU;
        if (cpuReq && dbgReq) begin
            grantId_c = (lastGrant == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbgReq) begin
            grantId_c = REQ_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory between the CPU control FSM and
// the debug/program-loader port, one transaction at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : gBadLat
        $error("mem_port_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MAX_MEM_LAT);
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    arbState_t         state, stateNext;
    logic [CNT_W-1:0]  waitCnt, waitCntNext;
    reqId_t            lastGrant, lastGrantNext;
    reqId_t            owner, ownerNext;
    logic              accWe, accWeNext;
    logic              memEnNext, memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic              cpuReadyNext, dbgReadyNext;
    logic [DATA_W-1:0] cpuRdataNext, dbgRdataNext;
    logic              grantValid;
    reqId_t            grantId;

    rr2_picker uPicker (
        .cpuReq       (cpu_req),
        .dbgReq       (dbg_req),
        .lastGrant    (lastGrant),
        .grantValid_c (grantValid),
        .grantId_c    (grantId)
    );

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            lastGrant <= REQ_DBG;
            owner     <= REQ_CPU;
            accWe     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ready <= 1'b0;
            dbg_ready <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            state     <= stateNext;
            waitCnt   <= waitCntNext;
            lastGrant <= lastGrantNext;
            owner     <= ownerNext;
            accWe     <= accWeNext;
            mem_en    <= memEnNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            cpu_ready <= cpuReadyNext;
            dbg_ready <= dbgReadyNext;
            cpu_rdata <= cpuRdataNext;
            dbg_rdata <= dbgRdataNext;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        stateNext     = state;
        waitCntNext   = waitCnt;
        lastGrantNext = lastGrant;
        ownerNext     = owner;
        accWeNext     = accWe;
        memEnNext     = 1'b0;
        memWeNext     = 1'b0;
        memAddrNext   = mem_addr;
        memWdataNext  = mem_wdata;
        cpuReadyNext  = 1'b0;
        dbgReadyNext  = 1'b0;
        cpuRdataNext  = cpu_rdata;
        dbgRdataNext  = dbg_rdata;

        case (state)
            IDLE: begin
                if (grantValid) begin
                    ownerNext     = grantId;
                    lastGrantNext = grantId;
                    memEnNext     = 1'b1;
                    stateNext     = ACCESS;
                    if (grantId == REQ_DBG) begin
                        accWeNext    = dbg_we;
                        memWeNext    = dbg_we;
                        memAddrNext  = dbg_addr;
                        memWdataNext = dbg_wdata;
                    end else begin
                        accWeNext    = cpu_we;
                        memWeNext    = cpu_we;
                        memAddrNext  = cpu_addr;
                        memWdataNext = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                if (accWe) begin
                    stateNext = RESP;
                    if (owner == REQ_CPU) cpuReadyNext = 1'b1;
                    else                  dbgReadyNext = 1'b1;
                end else begin
                    waitCntNext = CNT_INIT;
                    stateNext   = (MEM_LAT == 1) ? CAPT : WAIT;
                end
            end
            WAIT: begin
                waitCntNext = waitCnt - CNT_W'(1);
                if (waitCnt == CNT_W'(1)) stateNext = CAPT;
            end
            // mem_rdata is valid this cycle; ready and data land together next
            CAPT: begin
                stateNext = RESP;
                if (owner == REQ_CPU) begin
                    cpuRdataNext = mem_rdata;
                    cpuReadyNext = 1'b1;
                end else begin
                    dbgRdataNext = mem_rdata;
                    dbgReadyNext = 1'b1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter at MEM_LAT=1 (index 0) and
// MEM_LAT=3 (index 1), with a latency-accurate memory model per instance.
module tb_mem_port_arbiter;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memTxn_t;

    typedef struct packed {
        logic        isRead;
        logic [31:0] data;
    } rdyExp_t;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        cpuReq    [2];
    logic        cpuWe     [2];
    logic [31:0] cpuAddr   [2];
    logic [31:0] cpuWdata  [2];
    logic        cpuReady  [2];
    logic [31:0] cpuRdata  [2];
    logic        dbgReq    [2];
    logic        dbgWe     [2];
    logic [31:0] dbgAddr   [2];
    logic [31:0] dbgWdata  [2];
    logic        dbgReady  [2];
    logic [31:0] dbgRdata  [2];
    logic        memEn     [2];
    logic        memWe     [2];
    logic [31:0] memAddr   [2];
    logic [31:0] memWdata  [2];
    logic [31:0] memRdata  [2];

    memTxn_t     expMem [2][$];
    rdyExp_t     expCpu [2][$];
    rdyExp_t     expDbg [2][$];
    logic [31:0] memModel [logic [31:0]];
    int          pendCnt  [2];
    logic [31:0] pendData [2];
    int          nAssert = 0;
    int          nFail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dutLat1 (
        .clk(clk), .reset(reset[0]),
        .cpu_req(cpuReq[0]), .cpu_we(cpuWe[0]), .cpu_addr(cpuAddr[0]), .cpu_wdata(cpuWdata[0]),
        .cpu_ready(cpuReady[0]), .cpu_rdata(cpuRdata[0]),
        .dbg_req(dbgReq[0]), .dbg_we(dbgWe[0]), .dbg_addr(dbgAddr[0]), .dbg_wdata(dbgWdata[0]),
        .dbg_ready(dbgReady[0]), .dbg_rdata(dbgRdata[0]),
        .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]), .mem_wdata(memWdata[0]),
        .mem_rdata(memRdata[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dutLat3 (
        .clk(clk), .reset(reset[1]),
        .cpu_req(cpuReq[1]), .cpu_we(cpuWe[1]), .cpu_addr(cpuAddr[1]), .cpu_wdata(cpuWdata[1]),
        .cpu_ready(cpuReady[1]), .cpu_rdata(cpuRdata[1]),
        .dbg_req(dbgReq[1]), .dbg_we(dbgWe[1]), .dbg_addr(dbgAddr[1]), .dbg_wdata(dbgWdata[1]),
        .dbg_ready(dbgReady[1]), .dbg_rdata(dbgRdata[1]),
        .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]), .mem_wdata(memWdata[1]),
        .mem_rdata(memRdata[1])
    );

    function automatic int latOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rdModel(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issueCpu(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        memTxn_t t;
        rdyExp_t r;
        cpuReq[i] = 1'b1; cpuWe[i] = we; cpuAddr[i] = addr; cpuWdata[i] = wdata;
        t.we = we; t.addr = addr; t.wdata = wdata;
        r.isRead = !we; r.data = we ? 32'h0 : rdModel(addr);
        expMem[i].push_back(t);
        expCpu[i].push_back(r);
    endtask

    task automatic issueDbg(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        memTxn_t t;
        rdyExp_t r;
        dbgReq[i] = 1'b1; dbgWe[i] = we; dbgAddr[i] = addr; dbgWdata[i] = wdata;
        t.we = we; t.addr = addr; t.wdata = wdata;
        r.isRead = !we; r.data = we ? 32'h0 : rdModel(addr);
        expMem[i].push_back(t);
        expDbg[i].push_back(r);
    endtask

    // Memory model plus scoreboard pops for one instance, run every negedge
    task automatic monitorPort(input int i);
        memTxn_t t;
        rdyExp_t r;
        string   p;
        p = $sformatf("L%0d", latOf(i));
        if (pendCnt[i] > 0) begin
            pendCnt[i]--;
            memRdata[i] = (pendCnt[i] == 0) ? pendData[i] : JUNK;
        end else begin
            memRdata[i] = JUNK;
        end
        chk({p, " mem_we without mem_en"}, 32'(memWe[i] && !memEn[i]), 32'd0);
        chk({p, " both ready"}, 32'(cpuReady[i] && dbgReady[i]), 32'd0);
        if (memEn[i]) begin
            chk({p, " mem_en expected"}, 32'(expMem[i].size() != 0), 32'd1);
            if (expMem[i].size() != 0) begin
                t = expMem[i].pop_front();
                chk({p, " mem_we"}, 32'(memWe[i]), 32'(t.we));
                chk({p, " mem_addr"}, memAddr[i], t.addr);
                chk({p, " mem_wdata"}, memWdata[i], t.wdata);
            end
            if (memWe[i]) begin
                memModel[memAddr[i]] = memWdata[i];
            end else begin
                pendCnt[i]  = latOf(i);
                pendData[i] = rdModel(memAddr[i]);
            end
        end
        if (cpuReady[i]) begin
            chk({p, " cpu_ready expected"}, 32'(expCpu[i].size() != 0), 32'd1);
            if (expCpu[i].size() != 0) begin
                r = expCpu[i].pop_front();
                if (r.isRead) chk({p, " cpu_rdata"}, cpuRdata[i], r.data);
            end
        end
        if (dbgReady[i]) begin
            chk({p, " dbg_ready expected"}, 32'(expDbg[i].size() != 0), 32'd1);
            if (expDbg[i].size() != 0) begin
                r = expDbg[i].pop_front();
                if (r.isRead) chk({p, " dbg_rdata"}, dbgRdata[i], r.data);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pendCnt[i]  = 0;
            pendData[i] = '0;
            memRdata[i] = JUNK;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) monitorPort(i);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            cpuReq[i] = 1'b0; cpuWe[i] = 1'b0; cpuAddr[i] = '0; cpuWdata[i] = '0;
            dbgReq[i] = 1'b0; dbgWe[i] = 1'b0; dbgAddr[i] = '0; dbgWdata[i] = '0;
        end
        memModel[32'h10] = 32'h0000_0013;
        memModel[32'h20] = 32'hA5A5_A5A5;
        step(2);
        for (int i = 0; i < 2; i++) begin
            chk("reset mem_en", 32'(memEn[i]), 32'd0);
            chk("reset mem_we", 32'(memWe[i]), 32'd0);
            chk("reset cpu_ready", 32'(cpuReady[i]), 32'd0);
            chk("reset dbg_ready", 32'(dbgReady[i]), 32'd0);
            chk("reset mem_addr", memAddr[i], 32'd0);
            chk("reset mem_wdata", memWdata[i], 32'd0);
            chk("reset cpu_rdata", cpuRdata[i], 32'd0);
            chk("reset dbg_rdata", dbgRdata[i], 32'd0);
            reset[i] = 1'b0;
        end

        // T1: CPU read, MEM_LAT=1
        issueCpu(0, 1'b0, 32'h10, 32'h0);
        step(1);
        chk("T1 c1 mem_en", 32'(memEn[0]), 32'd1);
        chk("T1 c1 mem_we", 32'(memWe[0]), 32'd0);
        chk("T1 c1 mem_addr", memAddr[0], 32'h10);
        step(1);
        chk("T1 c2 mem_en", 32'(memEn[0]), 32'd0);
        chk("T1 c2 cpu_ready", 32'(cpuReady[0]), 32'd0);
        step(1);
        chk("T1 c3 cpu_ready", 32'(cpuReady[0]), 32'd1);
        chk("T1 c3 cpu_rdata", cpuRdata[0], 32'h13);
        chk("T1 c3 dbg_ready", 32'(dbgReady[0]), 32'd0);
        step(1);
        cpuReq[0] = 1'b0;
        chk("T1 c4 cpu_ready", 32'(cpuReady[0]), 32'd0);
        step(1);
        chk("T1 c5 no reissue", 32'(memEn[0]), 32'd0);
        chk("T1 c5 cpu_rdata held", cpuRdata[0], 32'h13);

        // T2: debug write
        issueDbg(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        step(1);
        chk("T2 c1 mem_en", 32'(memEn[0]), 32'd1);
        chk("T2 c1 mem_we", 32'(memWe[0]), 32'd1);
        chk("T2 c1 mem_addr", memAddr[0], 32'h40);
        chk("T2 c1 mem_wdata", memWdata[0], 32'hDEAD_BEEF);
        step(1);
        chk("T2 c2 dbg_ready", 32'(dbgReady[0]), 32'd1);
        chk("T2 c2 mem_we", 32'(memWe[0]), 32'd0);
        chk("T2 c2 cpu_ready", 32'(cpuReady[0]), 32'd0);
        step(1);
        dbgReq[0] = 1'b0;
        chk("T2 c3 dbg_ready", 32'(dbgReady[0]), 32'd0);
        chk("T2 c3 dbg_rdata held", dbgRdata[0], 32'd0);
        chk("T2 c3 mem_wdata held", memWdata[0], 32'hDEAD_BEEF);
        chk("T2 c3 cpu_rdata held", cpuRdata[0], 32'h13);

        // T3: simultaneous reads right after reset, then alternation
        reset[0] = 1'b1;
        step(1);
        reset[0] = 1'b0;
        issueCpu(0, 1'b0, 32'h100, 32'h0);
        issueDbg(0, 1'b0, 32'h200, 32'h0);
        step(1);
        chk("T3 c1 mem_en", 32'(memEn[0]), 32'd1);
        chk("T3 c1 cpu first", memAddr[0], 32'h100);
        step(2);
        chk("T3 c3 cpu_ready", 32'(cpuReady[0]), 32'd1);
        chk("T3 c3 dbg_ready", 32'(dbgReady[0]), 32'd0);
        step(1);
        issueCpu(0, 1'b0, 32'h104, 32'h0);
        chk("T3 c4 mem_en", 32'(memEn[0]), 32'd0);
        step(1);
        chk("T3 c5 mem_en", 32'(memEn[0]), 32'd1);
        chk("T3 c5 dbg granted", memAddr[0], 32'h200);
        step(2);
        chk("T3 c7 dbg_ready", 32'(dbgReady[0]), 32'd1);
        chk("T3 c7 dbg_rdata", dbgRdata[0], 32'h5A5A_0200);
        chk("T3 c7 cpu_ready", 32'(cpuReady[0]), 32'd0);
        step(1);
        dbgReq[0] = 1'b0;
        chk("T3 c8 mem_en", 32'(memEn[0]), 32'd0);
        step(1);
        chk("T3 c9 mem_en", 32'(memEn[0]), 32'd1);
        chk("T3 c9 cpu granted", memAddr[0], 32'h104);
        step(2);
        chk("T3 c11 cpu_ready", 32'(cpuReady[0]), 32'd1);
        step(1);
        cpuReq[0] = 1'b0;
        step(1);

        // T6: back-to-back CPU with req held through ready
        issueCpu(0, 1'b0, 32'h10, 32'h0);
        step(3);
        chk("T6 c3 cpu_ready", 32'(cpuReady[0]), 32'd1);
        chk("T6 c3 cpu_rdata", cpuRdata[0], 32'h13);
        step(1);
        issueCpu(0, 1'b0, 32'h14, 32'h0);
        chk("T6 c4 cpu_ready", 32'(cpuReady[0]), 32'd0);
        chk("T6 c4 mem_en", 32'(memEn[0]), 32'd0);
        step(1);
        chk("T6 c5 mem_en", 32'(memEn[0]), 32'd1);
        chk("T6 c5 mem_addr", memAddr[0], 32'h14);
        step(2);
        chk("T6 c7 cpu_ready", 32'(cpuReady[0]), 32'd1);
        chk("T6 c7 cpu_rdata", cpuRdata[0], 32'h5A5A_0014);
        step(1);
        cpuReq[0] = 1'b0;
        chk("T6 c8 cpu_ready", 32'(cpuReady[0]), 32'd0);

        // T4: MEM_LAT=3 read; a field change mid-transaction is ignored
        issueCpu(1, 1'b0, 32'h20, 32'h0);
        step(1);
        chk("T4 c1 mem_en", 32'(memEn[1]), 32'd1);
        chk("T4 c1 mem_addr", memAddr[1], 32'h20);
        step(1);
        cpuAddr[1] = 32'hFFFF_FFF0;
        chk("T4 c2 mem_en", 32'(memEn[1]), 32'd0);
        step(1);
        chk("T4 c3 mem_en", 32'(memEn[1]), 32'd0);
        chk("T4 c3 mem_addr held", memAddr[1], 32'h20);
        chk("T4 c3 cpu_ready", 32'(cpuReady[1]), 32'd0);
        step(1);
        chk("T4 c4 mem_en", 32'(memEn[1]), 32'd0);
        chk("T4 c4 cpu_ready", 32'(cpuReady[1]), 32'd0);
        step(1);
        chk("T4 c5 cpu_ready", 32'(cpuReady[1]), 32'd1);
        chk("T4 c5 cpu_rdata", cpuRdata[1], 32'hA5A5_A5A5);
        step(1);
        cpuReq[1] = 1'b0;
        chk("T4 c6 cpu_ready", 32'(cpuReady[1]), 32'd0);
        step(1);

        // T5: reset in WAIT abandons the read
        issueCpu(1, 1'b0, 32'h30, 32'h0);
        step(1);
        chk("T5 c1 mem_en", 32'(memEn[1]), 32'd1);
        step(1);
        reset[1] = 1'b1;
        step(1);
        reset[1] = 1'b0;
        cpuReq[1] = 1'b0;
        void'(expCpu[1].pop_back());
        chk("T5 c3 mem_en", 32'(memEn[1]), 32'd0);
        chk("T5 c3 mem_we", 32'(memWe[1]), 32'd0);
        chk("T5 c3 cpu_ready", 32'(cpuReady[1]), 32'd0);
        chk("T5 c3 dbg_ready", 32'(dbgReady[1]), 32'd0);
        chk("T5 c3 mem_addr", memAddr[1], 32'd0);
        chk("T5 c3 mem_wdata", memWdata[1], 32'd0);
        chk("T5 c3 cpu_rdata", cpuRdata[1], 32'd0);
        chk("T5 c3 dbg_rdata", dbgRdata[1], 32'd0);
        step(1);
        chk("T5 c4 mem_en", 32'(memEn[1]), 32'd0);
        step(2);
        issueCpu(1, 1'b0, 32'h30, 32'h0);
        step(1);
        chk("T5 reissue c1 mem_en", 32'(memEn[1]), 32'd1);
        step(4);
        chk("T5 reissue c5 cpu_ready", 32'(cpuReady[1]), 32'd1);
        chk("T5 reissue c5 cpu_rdata", cpuRdata[1], 32'h5A5A_0030);
        step(1);
        cpuReq[1] = 1'b0;

        // T7: debug write then read-back at MEM_LAT=3
        step(1);
        issueDbg(1, 1'b1, 32'h44, 32'h1234_5678);
        step(1);
        chk("T7 c1 mem_we", 32'(memWe[1]), 32'd1);
        chk("T7 c1 mem_wdata", memWdata[1], 32'h1234_5678);
        step(1);
        chk("T7 c2 dbg_ready", 32'(dbgReady[1]), 32'd1);
        chk("T7 c2 mem_we", 32'(memWe[1]), 32'd0);
        step(1);
        dbgReq[1] = 1'b0;
        step(1);
        issueDbg(1, 1'b0, 32'h44, 32'h0);
        step(5);
        chk("T7 c5 dbg_ready", 32'(dbgReady[1]), 32'd1);
        chk("T7 c5 dbg_rdata", dbgRdata[1], 32'h1234_5678);
        chk("T7 c5 cpu_rdata held", cpuRdata[1], 32'h5A5A_0030);
        step(1);
        dbgReq[1] = 1'b0;

        step(4);
        for (int i = 0; i < 2; i++) begin
            chk("drain mem queue", 32'(expMem[i].size()), 32'd0);
            chk("drain cpu queue", 32'(expCpu[i].size()), 32'd0);
            chk("drain dbg queue", 32'(expDbg[i].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
